ex_alu: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/ex_alu_mul_seq.sv | 79 +++++++
 rtl/ex_alu.sv | 61 ++++++
 tb/tb_ex_alu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline types: ALU control codes, EX multiplier FSM states
// and the default datapath width.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] ALUand = 4'b0000;
  localparam logic [3:0] ALUor  = 4'b0001;
  localparam logic [3:0] ALUadd = 4'b0010;
  localparam logic [3:0] ALUx   = 4'b0011;
  localparam logic [3:0] ALUsub = 4'b0110;
  localparam logic [3:0] ALUslt = 4'b0111;
  localparam logic [3:0] ALUmul = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ex_alu_mul_seq.sv
// Sequential shift-add multiplier for EX: one partial product per cycle,
// fixed WIDTH iterations, product held for a single DONE cycle.
module ex_alu_mul_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          busy     = 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = acc_q;

endmodule

// File: rtl/ex_alu.sv
// EX-stage ALU: single-cycle logic/arith ops plus a multi-cycle mul that
// holds Stall_EX until its product is presented.
module ex_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid_EX,
  input  logic [3:0]       ALU_Control_EX,
  input  logic [WIDTH-1:0] Operand_A_EX,
  input  logic [WIDTH-1:0] Operand_B_EX,
  output logic [WIDTH-1:0] ALU_Result_EX,
  output logic             Zero_EX,
  output logic             Stall_EX
);

  logic             is_mul;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] comb_res;

  assign is_mul = Valid_EX && (ALU_Control_EX == ALUmul);

  ex_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (is_mul),
    .a       (Operand_A_EX),
    .b       (Operand_B_EX),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always_comb begin
    comb_res = '0;
    case (ALU_Control_EX)
      ALUand: comb_res = Operand_A_EX & Operand_B_EX;
      ALUor:  comb_res = Operand_A_EX | Operand_B_EX;
      ALUadd: comb_res = Operand_A_EX + Operand_B_EX;
      ALUsub: comb_res = Operand_A_EX - Operand_B_EX;
      ALUslt: comb_res = {{(WIDTH-1){1'b0}},
                          $signed(Operand_A_EX) < $signed(Operand_B_EX)};
      default: comb_res = '0;
    endcase
  end

  // Reset gates the issue-cycle stall, which is otherwise combinational.
  always_comb begin
    ALU_Result_EX = comb_res;
    if (Reset || busy) ALU_Result_EX = '0;
    else if (done)     ALU_Result_EX = product;
  end

  assign Stall_EX = busy && !Reset;
  assign Zero_EX  = (ALU_Result_EX == '0);

endmodule

// File: tb/tb_ex_alu.sv
// Directed bench for ex_alu with a cycle-level reference model.
module tb_ex_alu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Valid_EX;
  logic [3:0]  ALU_Control_EX;
  logic [31:0] Operand_A_EX;
  logic [31:0] Operand_B_EX;
  logic [31:0] ALU_Result_EX;
  logic        Zero_EX;
  logic        Stall_EX;

  int tests = 0;
  int fails = 0;

  ex_alu #(.WIDTH(32)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Valid_EX       (Valid_EX),
    .ALU_Control_EX (ALU_Control_EX),
    .Operand_A_EX   (Operand_A_EX),
    .Operand_B_EX   (Operand_B_EX),
    .ALU_Result_EX  (ALU_Result_EX),
    .Zero_EX        (Zero_EX),
    .Stall_EX       (Stall_EX)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since mul issue (0 = no mul in flight).
  int          ph;
  logic [31:0] m_prod;

  function automatic logic [31:0] ref_op(input logic [3:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ph <= 0;
    end else if (ph == 0) begin
      if (Valid_EX && ALU_Control_EX == 4'hF) begin
        ph     <= 1;
        m_prod <= Operand_A_EX * Operand_B_EX;
      end
    end else if (ph == 33) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge Clk) begin
    logic [31:0] er;
    logic        es;
    er = 32'd0;
    es = 1'b0;
    if (Reset) begin
      er = 32'd0;
    end else if (ph == 0) begin
      if (Valid_EX && ALU_Control_EX == 4'hF) es = 1'b1;
      else er = ref_op(ALU_Control_EX, Operand_A_EX, Operand_B_EX);
    end else if (ph <= 32) begin
      es = 1'b1;
    end else begin
      er = m_prod;
    end
    check("model_result", ALU_Result_EX, er);
    check("model_zero", {31'd0, Zero_EX}, {31'd0, er == 32'd0});
    check("model_stall", {31'd0, Stall_EX}, {31'd0, es});
  end

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    Valid_EX       = v;
    ALU_Control_EX = c;
    Operand_A_EX   = a;
    Operand_B_EX   = b;
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic comb_op(input string name, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic ez);
    drive(v, c, a, b);
    #2;
    check({name, "_res"}, ALU_Result_EX, exp);
    check({name, "_zero"}, {31'd0, Zero_EX}, {31'd0, ez});
    check({name, "_stall"}, {31'd0, Stall_EX}, 32'd0);
    step;
  endtask

  task automatic run_mul(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input logic garble);
    int stalls;
    stalls = 0;
    drive(1'b1, 4'hF, a, b);
    #2;
    while (Stall_EX && stalls < 40) begin
      stalls++;
      step;
      if (garble) drive(1'b1, 4'b0010, $urandom, $urandom);
      #2;
    end
    check({name, "_stall_cycles"}, stalls, 32'd33);
    check({name, "_product"}, ALU_Result_EX, exp);
    check({name, "_zero"}, {31'd0, Zero_EX}, {31'd0, exp == 32'd0});
    check({name, "_done_stall"}, {31'd0, Stall_EX}, 32'd0);
    step;
    drive(1'b0, 4'b0010, 32'd0, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b1, 4'hF, 32'd3, 32'd4);
    #2;
    check("reset_res", ALU_Result_EX, 32'd0);
    check("reset_zero", {31'd0, Zero_EX}, 32'd1);
    check("reset_stall", {31'd0, Stall_EX}, 32'd0);
    step;
    step;
    Reset = 1'b0;
    drive(1'b0, 4'b0010, 32'd0, 32'd0);
    step;

    comb_op("add", 1'b1, 4'b0010, 32'd7, 32'd5, 32'd12, 1'b0);
    comb_op("sub", 1'b1, 4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
    comb_op("and", 1'b1, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0,
            32'h00F000F0, 1'b0);
    comb_op("or", 1'b1, 4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0,
            32'hFFF0FFF0, 1'b0);
    comb_op("slt_neg", 1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    comb_op("slt_false", 1'b1, 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1);
    comb_op("sub_zero", 1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1);
    comb_op("code_x", 1'b1, 4'b0011, 32'd5, 32'd6, 32'd0, 1'b1);
    comb_op("code_unlisted", 1'b1, 4'b1000, 32'd5, 32'd6, 32'd0, 1'b1);
    comb_op("mul_novalid", 1'b0, 4'hF, 32'd5, 32'd6, 32'd0, 1'b1);

    run_mul("mul_basic", 32'd12345, 32'd678, 32'd8369910, 1'b0);
    run_mul("mul_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_mul("mul_zero", 32'd0, 32'd1234, 32'd0, 1'b0);
    run_mul("mul_garble", 32'd1000, 32'd3000, 32'd3000000, 1'b1);
    run_mul("mul_b2b", 32'h00010000, 32'h00010001, 32'h00010000, 1'b0);

    drive(1'b1, 4'hF, 32'd100, 32'd200);
    step;
    for (int i = 1; i < 10; i++) step;
    Reset = 1'b1;
    #1;
    check("abort_stall", {31'd0, Stall_EX}, 32'd0);
    check("abort_res", ALU_Result_EX, 32'd0);
    check("abort_zero", {31'd0, Zero_EX}, 32'd1);
    step;
    #1;
    Reset = 1'b0;
    drive(1'b1, 4'b0010, 32'd1, 32'd1);
    #1;
    check("post_reset_add", ALU_Result_EX, 32'd2);
    check("post_reset_stall", {31'd0, Stall_EX}, 32'd0);
    step;
    run_mul("mul_after_reset", 32'd7, 32'd6, 32'd42, 1'b0);
    comb_op("tail_add", 1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
